// File: rtl/array_row_serializer.sv
// array_row_serializer
//   Captures one ROWS x COLS array of BIT_WIDTH-bit elements into a local
//   buffer and emits it one row per accepted beat. A new array may be
//   captured on the same edge that the last row transfers, so back-to-back
//   arrays stream with no bubble.
//
//   FSM states:
//     state | meaning
//     IDLE  | no array held; in_ready=1, out_valid=0
//     SEND  | array held; row row_idx presented on out_row
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     in_array holds a valid array
//   in_ready     block accepts an array this cycle
//   in_array     array to capture, in_array[r][c]
//   out_valid    out_row is valid
//   out_ready    consumer accepts the row
//   out_row      current row, out_row[c] = buffer[row_idx][c]
//   out_row_idx  index of the row on out_row
//   out_last     out_row is row ROWS-1
//   busy         array held, not fully drained
module array_row_serializer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_array [ROWS-1:0][COLS-1:0],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_row [COLS-1:0],
    output logic [ROW_IDX_W-1:0] out_row_idx,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

    logic [0:0]           state;
    logic [ROW_IDX_W-1:0] row_idx;
    logic [BIT_WIDTH-1:0] buffer [ROWS-1:0][COLS-1:0];

    logic in_send;
    logic is_last;
    logic beat;
    logic capture;

    assign in_send = (state == ST_SEND);
    assign is_last = (row_idx == LAST_ROW);
    assign beat    = in_send && out_ready;

    // A new array is only admitted when the buffer is empty or is being
    // emptied by the last-row transfer this very cycle.
    assign in_ready = !rst && (!in_send || (is_last && out_ready));
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            row_idx <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    buffer[r][c] <= '0;
                end
            end
        end else begin
            if (capture) begin
                buffer  <= in_array;
                row_idx <= '0;
                state   <= ST_SEND;
            end else if (beat) begin
                if (is_last) begin
                    row_idx <= '0;
                    state   <= ST_IDLE;
                end else begin
                    row_idx <= row_idx + 1'b1;
                end
            end
        end
    end

    assign out_valid   = in_send;
    assign busy        = in_send;
    assign out_last    = in_send && is_last;
    assign out_row_idx = row_idx;

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            out_row[c] = buffer[row_idx][c];
        end
    end

endmodule

// File: tb/tb_array_row_serializer.sv
module tb_array_row_serializer;

    logic       clk;
    logic       rst;

    // default-parameter instance
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [3:0] arr8 [7:0][7:0];
    logic [3:0] row8 [7:0];
    logic [2:0] idx8;

    // ROWS=1, COLS=3, BIT_WIDTH=8 instance
    logic       iv1, ir1, ov1, or1, last1, busy1;
    logic [7:0] arr1 [0:0][2:0];
    logic [7:0] row1 [2:0];
    logic [0:0] idx1;

    int n_cmp = 0;
    int n_err = 0;

    array_row_serializer dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_array(arr8),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(row8),
        .out_row_idx(idx8), .out_last(out_last), .busy(busy)
    );

    array_row_serializer #(.BIT_WIDTH(8), .ROWS(1), .COLS(3)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_array(arr1),
        .out_valid(ov1), .out_ready(or1), .out_row(row1),
        .out_row_idx(idx1), .out_last(last1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        bit          iv;
        bit          ordy;
        int          sel;
        bit          eir;
        bit          eov;
        int          eidx;
        bit          elast;
        bit          chk_row;
        logic [31:0] erow;
    } vec_t;

    vec_t tbl[$];

    // sel: 0 = (r*8+c) mod 16, 1 = all 0x3, 2 = all 0xC, 3 = all 0x5
    function automatic logic [3:0] elem(input int sel, input int r, input int c);
        case (sel)
            0:       return 4'((r * 8 + c) % 16);
            1:       return 4'h3;
            2:       return 4'hC;
            default: return 4'h5;
        endcase
    endfunction

    function automatic logic [31:0] exp_row(input int sel, input int r);
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < 8; c++) w[c*4 +: 4] = elem(sel, r, c);
        return w;
    endfunction

    task automatic set_arr(input int sel);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                arr8[r][c] = elem(sel, r, c);
    endtask

    function automatic logic [31:0] got_row8();
        logic [31:0] w;
        for (int c = 0; c < 8; c++) w[c*4 +: 4] = row8[c];
        return w;
    endfunction

    function automatic logic [31:0] got_row1();
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < 3; c++) w[c*8 +: 8] = row1[c];
        return w;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input bit iv, input bit ordy, input int sel,
                                input bit eir, input bit eov, input int eidx, input bit elast,
                                input bit chk_row, input logic [31:0] erow);
        vec_t v;
        v.name = nm; v.iv = iv; v.ordy = ordy; v.sel = sel;
        v.eir = eir; v.eov = eov; v.eidx = eidx; v.elast = elast;
        v.chk_row = chk_row; v.erow = erow;
        tbl.push_back(v);
    endfunction

    task automatic check8(input string nm, input bit eir, input bit eov, input int eidx,
                          input bit elast, input bit chk_row, input logic [31:0] erow);
        cmp({nm, ".in_ready"}, 32'(in_ready), 32'(eir));
        cmp({nm, ".out_valid"}, 32'(out_valid), 32'(eov));
        cmp({nm, ".busy"}, 32'(busy), 32'(eov));
        cmp({nm, ".idx"}, 32'(idx8), 32'(eidx));
        cmp({nm, ".last"}, 32'(out_last), 32'(elast));
        if (chk_row) cmp({nm, ".row"}, got_row8(), erow);
    endtask

    task automatic build_table();
        int r;
        int k;
        // single array, out_ready=1, in_array scrambled while sending
        add("single.cap", 1, 1, 0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++)
            add("single.beat", 0, 1, 3, (i == 7), 1, i, (i == 7), 1, exp_row(0, i));
        add("single.idle", 0, 1, 3, 1, 0, 0, 0, 0, '0);

        // backpressure, out_ready = 1,0,0,1,0,0,...
        add("bp.cap", 1, 1, 0, 1, 0, 0, 0, 0, '0);
        r = 0;
        k = 0;
        while (r < 8) begin
            bit ordy;
            ordy = (k % 3 == 0);
            add("bp.beat", 0, ordy, 2, (r == 7) && ordy, 1, r, (r == 7), 1, exp_row(0, r));
            if (ordy) r++;
            k++;
        end
        add("bp.idle", 0, 1, 2, 1, 0, 0, 0, 0, '0);

        // back-to-back A (0x3) then B (0xC), B captured on A's last beat
        add("b2b.capA", 1, 1, 1, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++)
            add("b2b.A", 1, 1, 2, (i == 7), 1, i, (i == 7), 1, exp_row(1, i));
        for (int i = 0; i < 8; i++)
            add("b2b.B", 0, 1, 3, (i == 7), 1, i, (i == 7), 1, exp_row(2, i));
        add("b2b.idle", 0, 1, 3, 1, 0, 0, 0, 0, '0);
    endtask

    initial begin
        bit found;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; set_arr(0);
        iv1 = 1'b0; or1 = 1'b0;
        for (int c = 0; c < 3; c++) arr1[0][c] = 8'h00;
        build_table();

        #2;
        cmp("rst.in_ready", 32'(in_ready), 32'd0);
        cmp("rst.in_ready1", 32'(ir1), 32'd0);
        #10;
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #4;
            check8("post_rst", 1, 0, 0, 0, 1, '0);
            cmp("post_rst.in_ready1", 32'(ir1), 32'd1);
            cmp("post_rst.out_valid1", 32'(ov1), 32'd0);
        end

        // ROWS=1: {1,2,3} then {4,5,6} back-to-back
        @(posedge clk); #1;
        iv1 = 1'b1; or1 = 1'b1;
        arr1[0][0] = 8'd1; arr1[0][1] = 8'd2; arr1[0][2] = 8'd3;
        #3;
        cmp("r1.cap.in_ready", 32'(ir1), 32'd1);
        cmp("r1.cap.out_valid", 32'(ov1), 32'd0);
        @(posedge clk); #1;
        arr1[0][0] = 8'd4; arr1[0][1] = 8'd5; arr1[0][2] = 8'd6;
        #3;
        cmp("r1.b0.out_valid", 32'(ov1), 32'd1);
        cmp("r1.b0.last", 32'(last1), 32'd1);
        cmp("r1.b0.idx", 32'(idx1), 32'd0);
        cmp("r1.b0.in_ready", 32'(ir1), 32'd1);
        cmp("r1.b0.row", got_row1(), 32'h00030201);
        @(posedge clk); #1;
        iv1 = 1'b0;
        arr1[0][0] = 8'd9; arr1[0][1] = 8'd9; arr1[0][2] = 8'd9;
        #3;
        cmp("r1.b1.out_valid", 32'(ov1), 32'd1);
        cmp("r1.b1.last", 32'(last1), 32'd1);
        cmp("r1.b1.idx", 32'(idx1), 32'd0);
        cmp("r1.b1.busy", 32'(busy1), 32'd1);
        cmp("r1.b1.row", got_row1(), 32'h00060504);
        @(posedge clk); #4;
        cmp("r1.idle.out_valid", 32'(ov1), 32'd0);
        cmp("r1.idle.busy", 32'(busy1), 32'd0);
        cmp("r1.idle.in_ready", 32'(ir1), 32'd1);

        // table-driven vectors
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            in_valid = tbl[i].iv;
            out_ready = tbl[i].ordy;
            set_arr(tbl[i].sel);
            #3;
            check8(tbl[i].name, tbl[i].eir, tbl[i].eov, tbl[i].eidx,
                   tbl[i].elast, tbl[i].chk_row, tbl[i].erow);
        end

        // mid-array reset at idx 4, then a fresh array C (0x5)
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1; set_arr(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (out_valid && idx8 == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        cmp("mid.reach_idx4", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check8("mid.rst", 0, 0, 0, 0, 1, '0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check8("mid.rel", 1, 0, 0, 0, 1, '0);
        in_valid = 1'b1; set_arr(3);
        @(posedge clk); #1;
        in_valid = 1'b0; set_arr(1);
        for (int r = 0; r < 8; r++) begin
            #3;
            check8("mid.C", (r == 7), 1, r, (r == 7), 1, exp_row(3, r));
            @(posedge clk); #1;
        end
        #3;
        check8("mid.idle", 1, 0, 0, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/array_row_serializer.md
Name: array_row_serializer

Overview:
- Downstream consumer of the conditional 2D-array select stage: captures one full ROWS x COLS array of BIT_WIDTH elements and emits it one row per accepted beat.
- Valid/ready on both sides; one-array buffer decouples the wide combinational selector from a narrow row-wide datapath.
- Sustained throughput: one array per ROWS cycles with no bubble between arrays.

Parameters:
- BIT_WIDTH, 4, element width in bits.
- ROWS, 8, rows per array (>=1).
- COLS, 8, elements per row (>=1).
- ROW_IDX_W (localparam), max($clog2(ROWS),1), width of the row index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_array holds a valid array.
- in_ready  output  1  block accepts an array this cycle.
- in_array  input  [BIT_WIDTH-1:0] [ROWS-1:0][COLS-1:0]  array to capture, same unpacked layout as the selector output.
- out_valid  output  1  out_row is valid.
- out_ready  input  1  consumer accepts the row.
- out_row  output  [BIT_WIDTH-1:0] [COLS-1:0]  current row, out_row[c] = buffer[row_idx][c].
- out_row_idx  output  ROW_IDX_W  index of the row on out_row.
- out_last  output  1  out_row is row ROWS-1.
- busy  output  1  array held, not fully drained.

Behaviour:
- Interface decided: single clock clk; rst asynchronous, active-high.
- Reset (asynchronous assert, takes effect immediately): state=IDLE, row_idx=0, buffer all zero, out_valid=0, out_last=0, busy=0, out_row_idx=0, out_row=0. in_ready=0 while rst is high; in_ready=1 from the first cycle after deassertion.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 captures in_array into buffer at the clock edge, sets row_idx=0, and moves to SEND.
- SEND:
  - out_valid=1, busy=1, out_row_idx=row_idx, out_last=(row_idx==ROWS-1).
  - A beat transfers when out_valid and out_ready are both 1.
  - On a non-last beat: row_idx increments by 1.
  - On a last beat with in_valid=0: go to IDLE and set row_idx=0.
  - On a last beat with in_valid=1 (same cycle): capture the new array, set row_idx=0, and stay in SEND. This gives zero-bubble back-to-back arrays.
- in_ready = IDLE, or (SEND and out_last and out_ready). This is a combinational path from out_ready to in_ready, and it is permitted.
- Latency: an array captured at edge N has its row 0 on out_row from cycle N+1. Minimum ROWS cycles per array.
- Stall: while out_valid=1 and out_ready=0, out_row, out_row_idx and out_last hold stable. The buffer is never modified in SEND except on the last-beat capture.
- in_array is sampled only on the capture edge. Changes to it at other times have no effect on the output.
- ROWS=1: out_last=1 throughout SEND. Each beat completes an array.
- No arithmetic on data; elements pass bit-exact. row_idx never exceeds ROWS-1 (no wrap past ROWS-1).
- rst asserted mid-array: current array is discarded immediately, all outputs return to reset values, and no partial rows are emitted after release.
- out_valid never depends combinationally on out_ready. in_array is never forwarded combinationally to out_row.

Test Plan:
- Default params. After reset, hold in_valid=0 for 5 cycles -> in_ready=1, out_valid=0, busy=0, out_row all 0.
- Single array, element[r][c]=(r*8+c) mod 16, out_ready=1 -> 8 consecutive beats: out_row_idx 0..7, row r elements equal (r*8+c) mod 16, out_last=1 only on idx 7, then IDLE.
- Backpressure: same array, out_ready toggled 1,0,0,1,... -> rows emitted in order, none duplicated or skipped; out_row stable during 0-cycles; in_ready=0 until the last-row transfer.
- Back-to-back: array A (all 0x3) then array B (all 0xC) with in_valid held high, out_ready=1 -> 16 consecutive valid beats with no gap; idx 0..7 give 0x3, then 0..7 give 0xC. B is captured on the cycle A's idx 7 transfers.
- Mid-array reset: assert rst at out_row_idx=4 -> out_valid drops immediately. After release, in_ready=1; a new array C (all 0x5) streams from idx 0 with no rows of the old array.
- ROWS=1, COLS=3, BIT_WIDTH=8, arrays {1,2,3} and {4,5,6} back-to-back -> two beats, out_last=1 on both, out_row_idx=0 on both.
